// File: rtl/kbd_event_seq.sv
// rtl/kbd_event_seq.sv - PS/2 set-2 prefix decoder with held-key tracking and FWFT event FIFO
module kbd_event_seq #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       evt_ready,
  input  logic       err_clr,
  output logic       evt_valid,
  output logic [7:0] evt_key,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       evt_rpt,
  output logic       is_press,
  output logic [7:0] held_key,
  output logic [7:0] press_count,
  output logic       ovf,
  output logic       proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] skip_cnt, skip_nxt;
  logic       ev_fire, ev_ext, ev_brk, ev_rpt, perr_set;
  logic       is_prefix, is_discard, held_match;
  logic       held_ext;

  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, pop, push;
  logic [10:0]   head;

  assign is_prefix  = (byte_data == 8'hE0) || (byte_data == 8'hF0) || (byte_data == 8'hE1);
  assign is_discard = (byte_data == 8'hAA) || (byte_data == 8'hFA) || (byte_data == 8'hEE) ||
                      (byte_data == 8'h00) || (byte_data == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    ev_fire   = 1'b0;
    ev_ext    = 1'b0;
    ev_brk    = 1'b0;
    perr_set  = 1'b0;
    if (byte_valid) begin
      case (state)
        S_IDLE: begin
          if (byte_data == 8'hE0) begin
            state_nxt = S_EXT;
          end else if (byte_data == 8'hF0) begin
            state_nxt = S_BRK;
          end else if (byte_data == 8'hE1) begin
            state_nxt = S_SKIP;
            skip_nxt  = 3'd7;
          end else if (!is_discard) begin
            ev_fire = 1'b1;
          end
        end
        S_EXT: begin
          if (byte_data == 8'hF0) begin
            state_nxt = S_EXT_BRK;
          end else begin
            state_nxt = S_IDLE;
            perr_set  = is_prefix;
            ev_fire   = !is_prefix;
            ev_ext    = 1'b1;
          end
        end
        S_BRK, S_EXT_BRK: begin
          state_nxt = S_IDLE;
          perr_set  = is_prefix;
          ev_fire   = !is_prefix;
          ev_ext    = (state == S_EXT_BRK);
          ev_brk    = 1'b1;
        end
        S_SKIP: begin
          // Pause is a fixed 8-byte blob with embedded prefixes; swallow it blind
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            state_nxt = S_IDLE;
            skip_nxt  = 3'd0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign held_match = (ev_ext == held_ext) && (byte_data == held_key);
  assign ev_rpt     = ev_fire && !ev_brk && is_press && held_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      is_press    <= 1'b0;
      held_key    <= 8'd0;
      held_ext    <= 1'b0;
      press_count <= 8'd0;
    end else if (ev_fire) begin
      if (!ev_brk && !ev_rpt) begin
        is_press    <= 1'b1;
        held_key    <= byte_data;
        held_ext    <= ev_ext;
        press_count <= press_count + 8'd1;
      end else if (ev_brk && held_match) begin
        is_press <= 1'b0;
      end
    end
  end

  assign evt_valid = (count != '0);
  assign full      = (count == CNT_FULL);
  assign pop       = evt_valid && evt_ready;
  // A full FIFO still takes a new event when the head leaves in the same cycle
  assign push      = ev_fire && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {ev_rpt, ev_ext, ev_brk, byte_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      ovf       <= (ev_fire && !push) || (ovf && !err_clr);
      proto_err <= perr_set || (proto_err && !err_clr);
    end
  end

  assign head    = evt_valid ? mem[rd_ptr] : 11'd0;
  assign evt_rpt = head[10];
  assign evt_ext = head[9];
  assign evt_brk = head[8];
  assign evt_key = head[7:0];

endmodule

// File: tb/tb_kbd_event_seq.sv
// tb/tb_kbd_event_seq.sv - scoreboard bench for kbd_event_seq
module tb_kbd_event_seq;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, byte_valid, evt_ready, err_clr;
  logic [7:0] byte_data;
  logic       evt_valid, evt_ext, evt_brk, evt_rpt, is_press, ovf, proto_err;
  logic [7:0] evt_key, held_key, press_count;

  always #5 clk = ~clk;

  kbd_event_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_ready(evt_ready), .err_clr(err_clr), .evt_valid(evt_valid),
    .evt_key(evt_key), .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_rpt(evt_rpt),
    .is_press(is_press), .held_key(held_key), .press_count(press_count),
    .ovf(ovf), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int popped   = 0;

  int          m_state;
  logic [2:0]  m_skip;
  logic        m_press, m_hext, m_ovf, m_perr;
  logic [7:0]  m_hkey, m_cnt;
  logic [10:0] mq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; err_clr = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    m_state = 0; m_skip = 3'd0; m_press = 1'b0; m_hext = 1'b0; m_ovf = 1'b0;
    m_perr = 1'b0; m_hkey = 8'h00; m_cnt = 8'h00; mq.delete(); popped = 0;
    check("reset_outputs", {evt_valid, evt_key, evt_ext, evt_brk, evt_rpt, is_press,
                            held_key, press_count, ovf, proto_err}, 32'd0);
  endtask

  // Drive one cycle; compare DUT head/status against the model, then advance the model.
  task automatic step(input logic bv, input logic [7:0] b);
    logic        pop, fire, ext, brk, rpt, match, pfx;
    logic [10:0] head;
    byte_valid = bv;
    byte_data  = b;
    head = {evt_rpt, evt_ext, evt_brk, evt_key};
    pop  = (mq.size() != 0) && evt_ready;
    check("evt_valid", {31'd0, evt_valid}, {31'd0, mq.size() != 0});
    if (mq.size() == 0) check("empty_head", {21'd0, head}, 32'd0);
    else if (pop)       check("evt", {21'd0, head}, {21'd0, mq[0]});
    check("status", {13'd0, is_press, held_key, press_count, ovf, proto_err},
                    {13'd0, m_press, m_hkey, m_cnt, m_ovf, m_perr});

    fire = 1'b0; ext = 1'b0; brk = 1'b0;
    pfx  = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
    if (err_clr) begin m_ovf = 1'b0; m_perr = 1'b0; end
    if (bv) begin
      case (m_state)
        0: begin
          if (b == 8'hE0) m_state = 1;
          else if (b == 8'hF0) m_state = 2;
          else if (b == 8'hE1) begin m_state = 4; m_skip = 3'd7; end
          else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF})) fire = 1'b1;
        end
        1: begin
          if (b == 8'hF0) m_state = 3;
          else begin
            m_state = 0;
            if (pfx) m_perr = 1'b1; else begin fire = 1'b1; ext = 1'b1; end
          end
        end
        2, 3: begin
          if (pfx) m_perr = 1'b1;
          else begin fire = 1'b1; brk = 1'b1; ext = (m_state == 3); end
          m_state = 0;
        end
        default: begin
          m_skip = m_skip - 3'd1;
          if (m_skip == 3'd0) m_state = 0;
        end
      endcase
    end
    if (pop) begin
      void'(mq.pop_front());
      popped++;
    end
    if (fire) begin
      match = (m_hext == ext) && (m_hkey == b);
      rpt   = !brk && m_press && match;
      if (!brk && !rpt) begin
        m_cnt = m_cnt + 8'd1; m_hkey = b; m_hext = ext; m_press = 1'b1;
      end else if (brk && match) begin
        m_press = 1'b0;
      end
      if (mq.size() < DEPTH) mq.push_back({rpt, ext, brk, b});
      else m_ovf = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    byte_valid = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; evt_ready = 1'b1; err_clr = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    do_reset();
    step(1'b1, 8'h1C);
    check("s1_head_make", {21'd0, evt_rpt, evt_ext, evt_brk, evt_key}, 32'h01C);
    check("s1_press_on", {31'd0, is_press}, 32'd1);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h1C);
    check("s1_head_brk", {21'd0, evt_rpt, evt_ext, evt_brk, evt_key}, 32'h11C);
    idle(3);
    check("s1_count", {24'd0, press_count}, 32'h01);
    check("s1_press_off", {31'd0, is_press}, 32'd0);
    check("s1_held", {24'd0, held_key}, 32'h1C);
    check("s1_events", popped, 2);

    do_reset();
    step(1'b1, 8'hE0); step(1'b1, 8'h75);
    step(1'b1, 8'hE0); step(1'b1, 8'h75);
    check("s2_head_rpt", {21'd0, evt_rpt, evt_ext, evt_brk, evt_key}, 32'h675);
    step(1'b1, 8'hE0); step(1'b1, 8'hF0); step(1'b1, 8'h75);
    idle(3);
    check("s2_count", {24'd0, press_count}, 32'h01);
    check("s2_press_off", {31'd0, is_press}, 32'd0);
    check("s2_events", popped, 3);

    do_reset();
    step(1'b1, 8'hE1); step(1'b1, 8'h14); step(1'b1, 8'h77); step(1'b1, 8'hE1);
    idle(2);
    step(1'b1, 8'hF0); step(1'b1, 8'h14); step(1'b1, 8'hF0); step(1'b1, 8'h77);
    check("s3_no_event", {31'd0, evt_valid}, 32'd0);
    step(1'b1, 8'h29);
    idle(3);
    check("s3_events", popped, 1);
    check("s3_count", {24'd0, press_count}, 32'h01);
    check("s3_held", {24'd0, held_key}, 32'h29);
    check("s3_perr", {31'd0, proto_err}, 32'd0);

    do_reset();
    step(1'b1, 8'hF0); step(1'b1, 8'hE0);
    check("s4_perr_set", {31'd0, proto_err}, 32'd1);
    check("s4_no_event", {31'd0, evt_valid}, 32'd0);
    step(1'b1, 8'h1C);
    check("s4_head", {21'd0, evt_rpt, evt_ext, evt_brk, evt_key}, 32'h01C);
    err_clr = 1'b1;
    step(1'b0, 8'h00);
    check("s4_perr_clr", {31'd0, proto_err}, 32'd0);
    step(1'b1, 8'hE0);
    do_reset();
    step(1'b1, 8'h1C);
    check("s4_rst_mid_seq", {21'd0, evt_rpt, evt_ext, evt_brk, evt_key}, 32'h01C);
    idle(2);

    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 8'h11 + 8'(i));
    check("s5_valid", {31'd0, evt_valid}, 32'd1);
    check("s5_ovf", {31'd0, ovf}, 32'd1);
    check("s5_count", {24'd0, press_count}, 32'h06);
    check("s5_head", {21'd0, evt_rpt, evt_ext, evt_brk, evt_key}, 32'h011);
    evt_ready = 1'b1;
    step(1'b1, 8'h17);
    idle(6);
    check("s5_events", popped, 5);
    check("s5_drained", {31'd0, evt_valid}, 32'd0);
    check("s5_ovf_sticky", {31'd0, ovf}, 32'd1);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] k;
      k = (i % 2 == 1) ? 8'h32 : 8'h1C;
      step(1'b1, k); step(1'b1, 8'hF0); step(1'b1, k);
      if (i == 254) check("s6_count_ff", {24'd0, press_count}, 32'hFF);
    end
    idle(3);
    check("s6_count_wrap", {24'd0, press_count}, 32'h00);
    check("s6_press_off", {31'd0, is_press}, 32'd0);
    check("s6_events", popped, 512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/kbd_event_seq.md
# kbd_event_seq

Scan-code sequencer between the PS/2 byte receiver and the keyboard display/ASCII datapath. It consumes raw PS/2 set-2 bytes and runs the prefix state machine (E0 extended, F0 break, E1 Pause skip). It emits one decoded key event per complete sequence into a small event FIFO with a ready/valid output. It also maintains the held-key flag and the press counter that drive the key and count displays.

## Interface
- DEPTH, 4, event FIFO entries; power of two, 2..16
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- byte_valid  in  1  single-cycle strobe: byte_data holds a new received byte
- byte_data  in  8  received scan byte
- evt_ready  in  1  downstream accepts head event when evt_valid & evt_ready
- err_clr  in  1  clears both sticky error flags
- evt_valid  out  1  FIFO non-empty
- evt_key  out  8  head event scan code (without prefixes)
- evt_ext  out  1  head event was E0-prefixed
- evt_brk  out  1  head event is a release
- evt_rpt  out  1  head event is a typematic repeat of the held key
- is_press  out  1  a key is currently held
- held_key  out  8  scan code of last pressed key, held after release
- press_count  out  8  number of non-repeat make events, modulo 256
- ovf  out  1  sticky: an event was dropped on a full FIFO
- proto_err  out  1  sticky: illegal prefix sequence seen

## Operation
- Decoder states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (Pause).
- IDLE:
  - E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip counter = 7.
  - AA, FA, EE, 00, FF are discarded; stay IDLE.
  - Any other byte -> make event {ext=0, brk=0}; stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - Any other non-prefix byte -> make event {ext=1}; -> IDLE.
- BRK: non-prefix byte -> break event {ext=0, brk=1}; -> IDLE.
- EXT_BRK: non-prefix byte -> break event {ext=1, brk=1}; -> IDLE.
- Prefix bytes (E0, F0, E1) arriving in EXT, BRK or EXT_BRK: byte discarded, proto_err set, -> IDLE. No event is generated.
- SKIP: each byte decrements the counter. The byte that takes the counter to 0 returns the decoder to IDLE. No event, no count.
- Make event handling:
  - If is_press=1 and {ext, key} equals the held {ext, key}: evt_rpt=1; press_count and held_key unchanged.
  - Otherwise: evt_rpt=0, press_count+1 (FF wraps to 00), held_key/held ext updated, is_press=1.
- Break event handling:
  - If it matches the held {ext, key}: is_press=0.
  - Otherwise held state is unchanged.
  - Break events always have evt_rpt=0.
- FIFO behaviour:
  - Each event is pushed as an 11-bit entry {rpt, ext, brk, key}.
  - Pop occurs when evt_valid & evt_ready.
  - Push when full without a same-cycle pop: event dropped, ovf set. held/count updates still apply.
  - Push when full with a same-cycle pop: accepted.
  - When empty, evt_key/evt_ext/evt_brk/evt_rpt drive 0.
- Sticky flags: err_clr clears ovf and proto_err. A set condition in the same cycle as err_clr wins (flag stays 1).

## Timing
- Reset: all outputs 0; decoder in IDLE; skip counter 0; FIFO empty; held ext 0.
- Reset mid-sequence (e.g. after E0): the prefix is lost and the next byte is decoded from IDLE.
- Event latency: the final byte sampled with byte_valid at edge N is written to the FIFO at edge N. evt_valid=1, and press_count/is_press/held_key are updated, from cycle N+1.
- FIFO is first-word-fall-through: head fields are valid in the same cycle evt_valid is high. A pop at edge M exposes the next entry from cycle M+1.
- Throughput: one byte per cycle is accepted; byte_valid is never back-pressured.
- byte_valid=0 cycles do not affect decoder state or the skip counter.

## Test plan
- Reset, then bytes 1C, F0 1C -> events {key=1C, brk=0, rpt=0} then {1C, brk=1}; press_count=01; is_press goes 1 then 0; held_key=1C.
- Bytes E0 75, E0 75, E0 F0 75 -> events {75, ext=1, rpt=0}, {75, ext=1, rpt=1}, {75, ext=1, brk=1}; press_count=01; is_press ends 0.
- Bytes E1 14 77 E1 F0 14 F0 77, then 29 -> exactly one event {29}; press_count=01; proto_err=0.
- Bytes F0 E0 -> no event, proto_err=1. Next byte 1C gives make event 1C. err_clr pulse clears proto_err.
- evt_ready=0 with DEPTH=4; six distinct makes -> evt_valid=1, first four events retained in order, ovf=1, press_count=06. Then hold evt_ready=1 -> four pops, then evt_valid=0.
- 256 distinct-alternating makes (1C, 32, 1C, 32, ... each followed by its break) -> press_count wraps to 00.
